// File: rtl/alu_muldiv_unit.sv
// Iterative RV32/64 M-extension multiply/divide unit.
// One shift-add or restoring-subtract step per cycle over XLEN cycles.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset
//   start   - begin an operation (sampled in IDLE only)
//   funct3  - op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b    - rs1 / rs2 operands
//   busy    - high while an operation is in flight (RUN and DONE)
//   done    - one-cycle pulse, result valid
//   result  - result of the last completed operation, held until the next
module alu_muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW   = $clog2(XLEN);
   localparam int unsigned PW   = 2 * XLEN;
   localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   acc_q, acc_d;    // product high half / partial remainder
   logic [XLEN-1:0]   lo_q, lo_d;      // multiplier->product low half / dividend->quotient
   logic [XLEN-1:0]   opb_q, opb_d;    // |b| (multiplicand-side addend or divisor)
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Operand preparation from the live inputs (used only on the start edge)
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf;

   always_comb begin
      a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                 (funct3 == OP_DIV)  || (funct3 == OP_REM);
      b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
      a_neg    = a_signed && a[XLEN-1];
      b_neg    = b_signed && b[XLEN-1];
      a_mag    = a_neg ? (~a + XLEN'(1)) : a;
      b_mag    = b_neg ? (~b + XLEN'(1)) : b;
      div_zero = funct3[2] && (b == '0);
      div_ovf  = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                 (a == MIN_VAL) && (b == {XLEN{1'b1}});
   end

   // One iteration step for multiply and divide
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift, div_diff;
   logic [XLEN-1:0] step_acc, step_lo;
   logic [PW-1:0]   prod, prod_fix;
   logic [XLEN-1:0] div_val, div_fix;
   logic [XLEN-1:0] final_res;

   always_comb begin
      mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
      div_shift = {acc_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      if (!op_q[2]) begin
         step_acc = mul_sum[XLEN:1];
         step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
         step_acc = div_diff[XLEN-1:0];
         step_lo  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
         step_acc = div_shift[XLEN-1:0];
         step_lo  = {lo_q[XLEN-2:0], 1'b0};
      end
      // Sign fix-up applied on the final step
      prod     = {step_acc, step_lo};
      prod_fix = neg_q ? (~prod + PW'(1)) : prod;
      div_val  = op_q[1] ? step_acc : step_lo;
      div_fix  = neg_q ? (~div_val + XLEN'(1)) : div_val;
      if (!op_q[2]) begin
         final_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
      end else begin
         final_res = div_fix;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = funct3;
               cnt_d = '0;
               if (div_zero) begin
                  result_d = funct3[1] ? a : {XLEN{1'b1}};
                  state_d  = DONE;
               end else if (div_ovf) begin
                  result_d = funct3[1] ? '0 : a;
                  state_d  = DONE;
               end else begin
                  acc_d   = '0;
                  lo_d    = a_mag;
                  opb_d   = b_mag;
                  // Remainder follows the dividend sign; everything else the sign product
                  neg_d   = (funct3 == OP_REM) ? a_neg : (a_neg ^ b_neg);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d = step_acc;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               result_d = final_res;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: doc/alu_muldiv_unit.md
ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, giving operand and result width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port start, input, 1, request to begin an operation.
REQ-005 SHALL provide port funct3, input, 3, RV M-extension op select:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-006 SHALL provide port a, input, XLEN, rs1 operand (multiplicand or dividend).
REQ-007 SHALL provide port b, input, XLEN, rs2 operand (multiplier or divisor).
REQ-008 SHALL provide port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL provide port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL provide port result, output, XLEN, final result of the last completed operation.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE.
REQ-012 In IDLE with start=1, SHALL latch a, b, funct3 at the clock edge, then go to RUN; the special cases of REQ-019 and REQ-020 go to DONE instead.
REQ-013 SHALL ignore start in RUN and DONE; latched operands are unaffected by later input changes.
REQ-014 RUN SHALL last exactly XLEN cycles, one shift-add (multiply) or restore-subtract (divide) step per cycle, then go to DONE.
REQ-015 DONE SHALL last one cycle with done=1 and result updated, then go to IDLE.
REQ-016 Latency SHALL be fixed, with the start cycle counted as cycle 0:
- normal operations: done=1 in cycle XLEN+1
- special cases: done=1 in cycle 1
REQ-017 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-018 Multiply SHALL form the 2*XLEN-bit product from operand magnitudes and negate it if the result is negative.
- MUL: low XLEN bits
- MULH: upper XLEN bits, signed×signed
- MULHSU: upper XLEN bits, signed a × unsigned b
- MULHU: upper XLEN bits, unsigned×unsigned
REQ-019 Division by zero SHALL yield:
- DIV/DIVU quotient: all ones
- REM/REMU remainder: a
REQ-020 Signed overflow (a = most negative value, b = all ones) SHALL yield:
- DIV quotient: a
- REM remainder: 0
REQ-021 Signed division SHALL divide magnitudes and then fix signs:
- quotient is negated when the operand signs differ (truncation toward zero)
- remainder takes the sign of a
REQ-022 result SHALL hold its value after DONE until the next DONE.
REQ-023 All arithmetic SHALL wrap modulo 2^XLEN (2^(2*XLEN) for the product) with no saturation.

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, busy=0, done=0, result=0 and clear internal accumulators and counters, including mid-operation.
REQ-025 After reset deasserts, the first start SHALL be accepted on the next rising clk edge.

Verification (XLEN=32)
REQ-026 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 33, busy high cycles 1-33.
REQ-027 Upper-half multiplies:
- MULH 0x80000000×0x80000000 -> 0x40000000
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE
- MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF
REQ-028 Signed division with a=0xFFFFFFF9 (-7), b=2:
- DIV -> 0xFFFFFFFD
- REM -> 0xFFFFFFFF
REQ-029 Special cases, each with done in cycle 1:
- DIVU 5/0 -> 0xFFFFFFFF
- REM 5/0 -> 5
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000
- REM same operands -> 0
REQ-030 start pulsed in cycle 10 of a running DIVU 100/7 -> ignored, result 14 in cycle 33.
REQ-031 reset pulled low in cycle 12 of a MUL -> busy=0, done=0, result=0 immediately, no done pulse afterward.
